// File: rtl/ddcb_pkg.sv
// Shared types and width helpers for the delay-tap sweep block.
// No logic, no latency; the sweep state encoding and sync depth live here.
package ddcb_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_DONE
  } sweep_state_e;

  function automatic int sel_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_tap_sweep_if.sv
// Host/delay-line bundle for delay_tap_sweep; master drives lines and controls.
// No storage; the sweep side never stalls the host, req is simply ignored while busy.
interface delay_tap_sweep_if #(
  parameter int TAPS     = 16,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = ddcb_pkg::sel_w(TAPS)
);
  logic [CHANNELS*TAPS-1:0]  delay_lines;
  logic                      mode;
  logic [CHANNELS*SEL_W-1:0] manual_sel;
  logic                      req;
  logic                      busy;
  logic                      done;
  logic [CHANNELS-1:0]       found;
  logic [CHANNELS*SEL_W-1:0] locked_sel;
  logic [CHANNELS-1:0]       out;

  modport master (
    output delay_lines, mode, manual_sel, req,
    input  busy, done, found, locked_sel, out
  );

  modport slave (
    input  delay_lines, mode, manual_sel, req,
    output busy, done, found, locked_sel, out
  );
endinterface

// File: rtl/tap_hit_counter.sv
// Per-channel 2-flop synchronizer feeding a hit counter with a majority flag.
// Sync adds 2 cycles before a sample can count; clear has priority over en.
module tap_hit_counter #(
  parameter int SAMPLES = 8,
  localparam int HW     = ddcb_pkg::cnt_w(SAMPLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic          din,
  output logic [HW-1:0] hits,
  output logic          majority
);
  import ddcb_pkg::*;

  localparam logic [HW-1:0] HALF = HW'(SAMPLES / 2);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [HW-1:0]          hits_q, hits_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    hits_d = hits_q;
    if (clear) begin
      hits_d = '0;
    end else if (en) begin
      hits_d = hits_q + HW'(sync_q[SYNC_STAGES-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hits_q <= '0;
    end else begin
      sync_q <= sync_d;
      hits_q <= hits_d;
    end
  end

  assign hits     = hits_q;
  assign majority = (hits_q >= HALF);
endmodule

// File: rtl/delay_tap_sweep.sv
// Multi-channel delay-line tap mux with a sweep FSM that locks the first tap sampling high.
// out is combinational from registered active_sel; each swept tap costs SETTLE+2+SAMPLES+1 cycles; req ignored while busy.
module delay_tap_sweep #(
  parameter int TAPS     = 16,
  parameter int CHANNELS = 2,
  parameter int SETTLE   = 4,
  parameter int SAMPLES  = 8,
  parameter int SEL_W    = ddcb_pkg::sel_w(TAPS)
) (
  input logic              clk,
  input logic              rst,
  delay_tap_sweep_if.slave bus
);
  import ddcb_pkg::*;

  localparam int SETTLE_CYC = SETTLE + SYNC_STAGES;
  localparam int SCW        = cnt_w(SETTLE_CYC);
  localparam int MCW        = cnt_w(SAMPLES);
  localparam int HW         = cnt_w(SAMPLES + 1);

  localparam logic [SEL_W-1:0] TAP_LAST    = SEL_W'(TAPS - 1);
  localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(SETTLE_CYC - 1);
  localparam logic [MCW-1:0]   SAMPLE_LAST = MCW'(SAMPLES - 1);

  typedef logic [CHANNELS-1:0][SEL_W-1:0] sel_vec_t;

  sweep_state_e              state_q, state_d;
  logic [SEL_W-1:0]          tap_q, tap_d;
  logic [SCW-1:0]            settle_cnt_q, settle_cnt_d;
  logic [MCW-1:0]            sample_cnt_q, sample_cnt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [CHANNELS-1:0]       found_q, found_d;
  sel_vec_t                  locked_sel_q, locked_sel_d;
  sel_vec_t                  active_sel_q, active_sel_d;
  sel_vec_t                  manual_v;
  logic                      hit_clear;
  logic                      sweeping_d;
  logic [CHANNELS-1:0]       majority;
  logic [CHANNELS-1:0][HW-1:0] hits;
  logic [TAPS-1:0]           line_c;

  assign manual_v = bus.manual_sel;

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    settle_cnt_d = settle_cnt_q;
    sample_cnt_d = sample_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    found_d      = found_q;
    locked_sel_d = locked_sel_q;
    hit_clear    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req && bus.mode) begin
          state_d      = ST_SETTLE;
          tap_d        = '0;
          settle_cnt_d = '0;
          busy_d       = 1'b1;
          found_d      = '0;
          hit_clear    = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = '0;
          sample_cnt_d = '0;
          state_d      = ST_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (sample_cnt_q == SAMPLE_LAST) begin
          sample_cnt_d = '0;
          state_d      = ST_EVAL;
        end else begin
          sample_cnt_d = sample_cnt_q + 1'b1;
        end
      end
      ST_EVAL: begin
        hit_clear = 1'b1;
        // Only the first qualifying tap is kept; later taps cannot move a lock.
        for (int c = 0; c < CHANNELS; c++) begin
          if (!found_q[c] && majority[c] && (hits[c] != '0)) begin
            found_d[c]      = 1'b1;
            locked_sel_d[c] = tap_q;
          end
        end
        if ((tap_q == TAP_LAST) || (&found_d)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          tap_d   = tap_q + 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Selection follows the next state so the swept tap lands on the same edge as the FSM.
  always_comb begin
    sweeping_d   = state_d inside {ST_SETTLE, ST_SAMPLE, ST_EVAL};
    active_sel_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sweeping_d) begin
        active_sel_d[c] = tap_d;
      end else if (!bus.mode) begin
        active_sel_d[c] = (manual_v[c] > TAP_LAST) ? TAP_LAST : manual_v[c];
      end else begin
        active_sel_d[c] = locked_sel_d[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tap_q        <= '0;
      settle_cnt_q <= '0;
      sample_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= '0;
      locked_sel_q <= '0;
      active_sel_q <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      settle_cnt_q <= settle_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      found_q      <= found_d;
      locked_sel_q <= locked_sel_d;
      active_sel_q <= active_sel_d;
    end
  end

  always_comb begin
    line_c  = '0;
    bus.out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      line_c     = bus.delay_lines[c*TAPS +: TAPS];
      bus.out[c] = line_c[active_sel_q[c]];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    tap_hit_counter #(.SAMPLES(SAMPLES)) u_hit (
      .clk      (clk),
      .rst      (rst),
      .clear    (hit_clear),
      .en       (state_q == ST_SAMPLE),
      .din      (bus.out[g]),
      .hits     (hits[g]),
      .majority (majority[g])
    );
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.found      = found_q;
  assign bus.locked_sel = locked_sel_q;
endmodule

// File: doc/delay_tap_sweep.md
Name: delay_tap_sweep

Overview:
- Multi-channel delay-line tap selector with a built-in calibration sweep.
- Each channel receives TAPS delayed copies of one signal and forwards one of them to its output.
- In manual mode the tap comes from a registered host value.
- In sweep mode an FSM steps every tap, majority-samples each channel's selected output, and locks the first tap where that output samples high. Used to align data/strobe edges to clk without host intervention.

Parameters:
- TAPS, 16, delay taps per channel (>=2, need not be a power of 2).
- CHANNELS, 2, independent delay channels.
- SETTLE, 4, idle cycles after each tap change before sampling (>=1).
- SAMPLES, 8, samples taken per tap (>=2, even).
- SEL_W, $clog2(TAPS), derived; tap index width.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- delay_lines  in  CHANNELS*TAPS  channel c, tap t at bit c*TAPS+t; asynchronous to clk.
- mode  in  1  0 = manual, 1 = sweep/locked.
- manual_sel  in  CHANNELS*SEL_W  per-channel manual tap; channel c at bits [c*SEL_W +: SEL_W].
- req  in  1  start sweep; sampled only in IDLE with mode=1.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- found  out  CHANNELS  channel locked during last sweep.
- locked_sel  out  CHANNELS*SEL_W  locked tap per channel.
- out  out  CHANNELS  selected tap per channel (combinational mux of delay_lines by active_sel).

Behaviour:
- Reset values:
  - busy=0, done=0, found=0, locked_sel=0.
  - active_sel=0 for every channel, so out follows tap 0.
  - FSM=IDLE; tap counter, settle counter, sample counter and hit counters all 0.
- active_sel (registered, per channel):
  - IDLE & mode=0: manual_sel, 1-cycle latency. Values >= TAPS clamp to TAPS-1.
  - IDLE & mode=1: locked_sel.
  - busy=1: the sweep tap, common to all channels.
- Sampling path:
  - out[c] passes through a 2-flop synchronizer before counting.
  - The settle window is therefore SETTLE+2 cycles.
- FSM states: IDLE, SETTLE, SAMPLE, EVAL, DONE.
  - IDLE: on req & mode=1, go to SETTLE next cycle with tap=0, busy=1, found cleared, hit counters cleared. req in any other state, or with mode=0, is ignored.
  - SETTLE: count SETTLE+2 cycles, then go to SAMPLE.
  - SAMPLE: for SAMPLES cycles, add the synced bit into each channel's hit counter (width $clog2(SAMPLES+1)), then go to EVAL.
  - EVAL (1 cycle):
    - For each channel with found[c]=0 and hits >= SAMPLES/2: set found[c]=1 and locked_sel[c]=tap.
    - Clear hit counters.
    - If tap==TAPS-1, or every channel is found after this update, go to DONE.
    - Otherwise tap+1 and go to SETTLE.
  - DONE: done=1 for exactly 1 cycle, busy=0 on that cycle, then IDLE.
- Channels not found keep their previous locked_sel. A failed sweep does not overwrite a good lock.
- Cost per tap = SETTLE+2+SAMPLES+1 cycles.
- Tap counter never wraps. A sweep covers at most TAPS taps.
- mode changes while busy are ignored until return to IDLE.
- rst asserted mid-sweep: on the next edge all state returns to reset values, including locked_sel and found.

Decomposition:
- Package ddcb_pkg holds:
  - sweep_state_e enum (IDLE, SETTLE, SAMPLE, EVAL, DONE);
  - functions sel_w(TAPS) and cnt_w(N) wrapping $clog2;
  - constant SYNC_STAGES=2.
- Sub-module tap_hit_counter, one per channel:
  - ports clk, rst, clear, en, din;
  - contains the 2-flop sync and the hit counter;
  - outputs hits and majority (hits >= SAMPLES/2).
  Top holds the FSM, tap/settle/sample counters, active_sel and lock registers, and the output mux.

Test Plan:
- Reset: hold rst 3 cycles → busy=0, done=0, found=2'b00, locked_sel=0, out[c] tracks delay_lines[c*16+0].
- Manual mode, clamp: mode=0, TAPS=12, manual_sel ch0=5, ch1=14 → one cycle later out[0]=tap 5, out[1]=tap 11.
- Sweep, defaults: drive ch0 taps 0-6 low and 7-15 high; ch1 taps 0-2 low and 3-15 high; pulse req → found=2'b11, locked_sel ch0=7, ch1=3, done asserted 8*15=120 cycles after req. Early exit once all channels are found.
- No edge: ch1 all low with prior lock=9 → done after 16*15=240 cycles, found[1]=0, locked_sel ch1 stays 9.
- Noisy taps: tap 4 sampled high 3/8 and tap 5 sampled high 4/8 → lock=5.
- Reset mid-sweep and request while busy:
  - rst during SAMPLE of tap 6 → next cycle IDLE, busy=0, locked_sel=0.
  - req pulses while busy → no restart; exactly one done pulse per sweep.
